// File: rtl/pipe_hazard_ctrl_if.sv
// Interface between the pipeline decode stage and the hazard/forwarding controller.
// The pipeline side (master) presents the decode-stage instruction and the
// branch resolution; the controller side (slave) returns stall, flush,
// forwarding selects, scoreboard occupancy and the stall counter.
interface pipe_hazard_ctrl_if #(
  parameter int NUM_STAGES = 3,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 16
);
  localparam int SELW = $clog2(NUM_STAGES + 1);

  // decode-stage instruction and pipeline control
  logic                  enable;
  logic                  id_valid;
  logic [REG_AW-1:0]     id_rs;
  logic [REG_AW-1:0]     id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic                  id_reg_write;
  logic                  id_mem_to_reg;
  logic [REG_AW-1:0]     id_dst;
  logic                  branch_taken;

  // controller responses
  logic                  stall;
  logic                  flush_if_id;
  logic [SELW-1:0]       fwd_a;
  logic [SELW-1:0]       fwd_b;
  logic [NUM_STAGES-1:0] stage_valid;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output enable, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_reg_write, id_mem_to_reg, id_dst, branch_taken,
    input  stall, flush_if_id, fwd_a, fwd_b, stage_valid, stall_count
  );

  modport slave (
    input  enable, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_reg_write, id_mem_to_reg, id_dst, branch_taken,
    output stall, flush_if_id, fwd_a, fwd_b, stage_valid, stall_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the in-order integer pipeline.
// Keeps a shadow scoreboard (valid, reg_write, load, destination) of every
// instruction past decode, one entry per stage (index k-1 holds stage k).
// From it, combinationally: operand forwarding selects (youngest writer wins),
// load-use stall, IF/ID flush for taken decode-stage branches.
// Registered: the scoreboard itself and a saturating stall counter.
// Legal ranges: NUM_STAGES 1..7, LOAD_READY 1..NUM_STAGES.
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES = 3,
  parameter int REG_AW     = 5,
  parameter int LOAD_READY = 3,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int SELW = $clog2(NUM_STAGES + 1);
  localparam logic [SELW-1:0]  LOAD_READY_SEL = SELW'(LOAD_READY);
  localparam logic [CNT_W-1:0] CNT_MAX        = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);

  // scoreboard state
  logic [NUM_STAGES-1:0] r_v;
  logic [NUM_STAGES-1:0] r_w;
  logic [NUM_STAGES-1:0] r_l;
  logic [REG_AW-1:0]     r_d [NUM_STAGES];
  logic [CNT_W-1:0]      r_cnt;

  // match / hazard evaluation
  logic            w_hit_a;
  logic            w_hit_b;
  logic            w_load_a;
  logic            w_load_b;
  logic [SELW-1:0] w_sel_a;
  logic [SELW-1:0] w_sel_b;
  logic            w_haz_a;
  logic            w_haz_b;
  logic            w_run;
  logic            w_stall;
  logic            w_flush;
  logic [SELW-1:0] w_fwd_a;
  logic [SELW-1:0] w_fwd_b;

  // Priority search for each operand: scan oldest to youngest so that the
  // youngest matching writer (smallest stage index) overrides older ones.
  // Register 0 is hard-wired zero and never matches.
  always_comb begin
    w_hit_a  = 1'b0;
    w_load_a = 1'b0;
    w_sel_a  = {SELW{1'b0}};
    w_hit_b  = 1'b0;
    w_load_b = 1'b0;
    w_sel_b  = {SELW{1'b0}};
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (r_v[k-1] && r_w[k-1] && (r_d[k-1] == bus.id_rs) &&
          (bus.id_rs != {REG_AW{1'b0}}) && bus.id_uses_rs) begin
        w_hit_a  = 1'b1;
        w_load_a = r_l[k-1];
        w_sel_a  = SELW'(k);
      end else begin
        w_hit_a  = w_hit_a;
        w_load_a = w_load_a;
        w_sel_a  = w_sel_a;
      end
      if (r_v[k-1] && r_w[k-1] && (r_d[k-1] == bus.id_rt) &&
          (bus.id_rt != {REG_AW{1'b0}}) && bus.id_uses_rt) begin
        w_hit_b  = 1'b1;
        w_load_b = r_l[k-1];
        w_sel_b  = SELW'(k);
      end else begin
        w_hit_b  = w_hit_b;
        w_load_b = w_load_b;
        w_sel_b  = w_sel_b;
      end
    end
  end

  // Load-use hazard: the winning producer is a load whose data only exists
  // from stage LOAD_READY onward. Outputs are forced quiet while in reset.
  always_comb begin
    w_haz_a = w_hit_a & w_load_a & (w_sel_a < LOAD_READY_SEL);
    w_haz_b = w_hit_b & w_load_b & (w_sel_b < LOAD_READY_SEL);
    w_run   = rst & bus.id_valid;
    w_stall = w_run & (w_haz_a | w_haz_b);
    // stall wins over flush: branch operands are not ready, re-evaluate next cycle
    w_flush = w_run & bus.branch_taken & ~w_stall;
    if (w_run && !w_stall) begin
      w_fwd_a = w_sel_a;
      w_fwd_b = w_sel_b;
    end else begin
      w_fwd_a = {SELW{1'b0}};
      w_fwd_b = {SELW{1'b0}};
    end
  end

  // Scoreboard shift: stage 1 takes the decode instruction (bubble on stall),
  // each older stage takes its younger neighbour, the last entry retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v <= {NUM_STAGES{1'b0}};
      r_w <= {NUM_STAGES{1'b0}};
      r_l <= {NUM_STAGES{1'b0}};
      for (int k = 0; k < NUM_STAGES; k++) begin
        r_d[k] <= {REG_AW{1'b0}};
      end
    end else if (bus.enable) begin
      for (int k = NUM_STAGES - 1; k >= 1; k--) begin
        r_v[k] <= r_v[k-1];
        r_w[k] <= r_w[k-1];
        r_l[k] <= r_l[k-1];
        r_d[k] <= r_d[k-1];
      end
      r_v[0] <= bus.id_valid & ~w_stall;
      r_w[0] <= bus.id_reg_write;
      r_l[0] <= bus.id_mem_to_reg;
      r_d[0] <= bus.id_dst;
    end
  end

  // Saturating count of enabled stall cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (bus.enable && w_stall && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign bus.stall       = w_stall;
  assign bus.flush_if_id = w_flush;
  assign bus.fwd_a       = w_fwd_a;
  assign bus.fwd_b       = w_fwd_b;
  assign bus.stage_valid = r_v;
  assign bus.stall_count = r_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, hand-written
// reset/enable sequences, randomized traffic against a queue-based model, and a
// CNT_W=4 instance for counter saturation.
module tb_pipe_hazard_ctrl;

  localparam int NS = 3;
  localparam int LR = 3;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NUM_STAGES(NS), .REG_AW(5), .CNT_W(16)) bus  ();
  pipe_hazard_ctrl_if #(.NUM_STAGES(NS), .REG_AW(5), .CNT_W(4))  bus2 ();

  pipe_hazard_ctrl #(.NUM_STAGES(NS), .REG_AW(5), .LOAD_READY(LR), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  pipe_hazard_ctrl #(.NUM_STAGES(NS), .REG_AW(5), .LOAD_READY(LR), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2)
  );

  typedef struct {
    int en, v, rs, rt, urs, urt, rw, mtr, dst, br;
    int e_stall, e_flush, e_fa, e_fb, e_sv, e_cnt;
  } vec_t;

  typedef struct {
    bit v, w, l;
    int d;
  } ent_t;

  vec_t tbl [28];
  ent_t q [$];
  int   m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int en, v, rs, rt, urs, urt, rw, mtr, dst, br,
                              input int s, f, fa, fb, sv, cnt);
    vec_t r;
    r.en = en; r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
    r.rw = rw; r.mtr = mtr; r.dst = dst; r.br = br;
    r.e_stall = s; r.e_flush = f; r.e_fa = fa; r.e_fb = fb; r.e_sv = sv; r.e_cnt = cnt;
    return r;
  endfunction

  task automatic drive(input int en, v, rs, rt, urs, urt, rw, mtr, dst, br);
    bus.enable        = 1'(en);
    bus.id_valid      = 1'(v);
    bus.id_rs         = 5'(rs);
    bus.id_rt         = 5'(rt);
    bus.id_uses_rs    = 1'(urs);
    bus.id_uses_rt    = 1'(urt);
    bus.id_reg_write  = 1'(rw);
    bus.id_mem_to_reg = 1'(mtr);
    bus.id_dst        = 5'(dst);
    bus.branch_taken  = 1'(br);
  endtask

  // Model: youngest in-flight writer of a register; age 0 is stage 1.
  function automatic int find_stage(input int r, input int uses, output bit is_load);
    is_load = 1'b0;
    if (r == 0 || uses == 0) return 0;
    foreach (q[i]) begin
      if (q[i].v && q[i].w && q[i].d == r) begin
        is_load = q[i].l;
        return i + 1;
      end
    end
    return 0;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < NS; i++) q.push_back('{v: 1'b0, w: 1'b0, l: 1'b0, d: 0});
    m_cnt = 0;
  endtask

  initial begin
    // ALU chain
    tbl[0]  = mk(1,1,0,0,0,0,1,0,3,0, 0,0,0,0,3'b000,0);
    tbl[1]  = mk(1,1,3,0,1,0,0,0,0,0, 0,0,1,0,3'b001,0);
    tbl[2]  = mk(1,1,3,0,1,0,0,0,0,0, 0,0,2,0,3'b011,0);
    tbl[3]  = mk(1,1,3,0,1,0,0,0,0,0, 0,0,3,0,3'b111,0);
    tbl[4]  = mk(1,1,3,0,1,0,0,0,0,0, 0,0,0,0,3'b111,0);
    // drain with bubbles
    tbl[5]  = mk(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,3'b111,0);
    tbl[6]  = mk(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,3'b110,0);
    tbl[7]  = mk(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,3'b100,0);
    // load r5, dependent reads rt=5
    tbl[8]  = mk(1,1,0,0,0,0,1,1,5,0, 0,0,0,0,3'b000,0);
    tbl[9]  = mk(1,1,0,5,0,1,0,0,0,0, 1,0,0,0,3'b001,0);
    tbl[10] = mk(1,1,0,5,0,1,0,0,0,0, 1,0,0,0,3'b010,1);
    tbl[11] = mk(1,1,0,5,0,1,0,0,0,0, 0,0,0,3,3'b100,2);
    // r0 writer, r0 reader (also writes r7), second r7 writer, r7 reader
    tbl[12] = mk(1,1,0,0,0,0,1,0,0,0, 0,0,0,0,3'b001,2);
    tbl[13] = mk(1,1,0,0,1,0,1,0,7,0, 0,0,0,0,3'b011,2);
    tbl[14] = mk(1,1,0,0,0,0,1,0,7,0, 0,0,0,0,3'b111,2);
    tbl[15] = mk(1,1,7,0,1,0,0,0,0,0, 0,0,1,0,3'b111,2);
    // branch without hazard, then branch stuck behind load-use
    tbl[16] = mk(1,1,0,0,0,0,0,0,0,1, 0,1,0,0,3'b111,2);
    tbl[17] = mk(1,1,0,0,0,0,1,1,5,0, 0,0,0,0,3'b111,2);
    tbl[18] = mk(1,1,5,0,1,0,0,0,0,1, 1,0,0,0,3'b111,2);
    tbl[19] = mk(1,1,5,0,1,0,0,0,0,1, 1,0,0,0,3'b110,3);
    tbl[20] = mk(1,1,5,0,1,0,0,0,0,1, 0,1,3,0,3'b100,4);
    // load r6, dependent stalls, enable low for 3 cycles mid-stall
    tbl[21] = mk(1,1,0,0,0,0,1,1,6,0, 0,0,0,0,3'b001,4);
    tbl[22] = mk(1,1,6,0,1,0,0,0,0,0, 1,0,0,0,3'b011,4);
    tbl[23] = mk(0,1,6,0,1,0,0,0,0,0, 1,0,0,0,3'b110,5);
    tbl[24] = mk(0,1,6,0,1,0,0,0,0,0, 1,0,0,0,3'b110,5);
    tbl[25] = mk(0,1,6,0,1,0,0,0,0,0, 1,0,0,0,3'b110,5);
    tbl[26] = mk(1,1,6,0,1,0,0,0,0,0, 1,0,0,0,3'b110,5);
    tbl[27] = mk(1,1,6,0,1,0,0,0,0,0, 0,0,3,0,3'b100,6);

    // second instance held in reset until the saturation phase
    rst2 = 1'b0;
    bus2.enable = 1'b1; bus2.id_valid = 1'b1; bus2.id_rs = 5'd0; bus2.id_rt = 5'd5;
    bus2.id_uses_rs = 1'b0; bus2.id_uses_rt = 1'b1; bus2.id_reg_write = 1'b1;
    bus2.id_mem_to_reg = 1'b1; bus2.id_dst = 5'd5; bus2.branch_taken = 1'b0;

    // reset state: outputs forced quiet even with a valid taken branch
    rst = 1'b0;
    drive(1,1,3,3,1,1,1,1,3,1);
    #2;
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_flush", 32'(bus.flush_if_id), 32'd0);
    chk("rst_fwd_a", 32'(bus.fwd_a), 32'd0);
    chk("rst_sv",    32'(bus.stage_valid), 32'd0);
    chk("rst_cnt",   32'(bus.stall_count), 32'd0);
    drive(1,0,0,0,0,0,0,0,0,0);
    @(posedge clk); #1;
    rst = 1'b1;

    // directed vector table
    for (int i = 0; i < 28; i++) begin
      drive(tbl[i].en, tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt,
            tbl[i].rw, tbl[i].mtr, tbl[i].dst, tbl[i].br);
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), 32'(bus.stall),       32'(tbl[i].e_stall));
      chk($sformatf("vec%0d_flush", i), 32'(bus.flush_if_id), 32'(tbl[i].e_flush));
      chk($sformatf("vec%0d_fwd_a", i), 32'(bus.fwd_a),       32'(tbl[i].e_fa));
      chk($sformatf("vec%0d_fwd_b", i), 32'(bus.fwd_b),       32'(tbl[i].e_fb));
      chk($sformatf("vec%0d_sv", i),    32'(bus.stage_valid), 32'(tbl[i].e_sv));
      chk($sformatf("vec%0d_cnt", i),   32'(bus.stall_count), 32'(tbl[i].e_cnt));
      @(posedge clk); #1;
    end

    // asynchronous reset in the middle of a load-use stall
    drive(1,1,0,0,0,0,1,1,5,0);
    @(posedge clk); #1;
    drive(1,1,0,5,0,1,0,0,0,1);
    @(negedge clk);
    chk("midrst_pre_stall", 32'(bus.stall), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_stall", 32'(bus.stall), 32'd0);
    chk("midrst_flush", 32'(bus.flush_if_id), 32'd0);
    chk("midrst_fwd_b", 32'(bus.fwd_b), 32'd0);
    chk("midrst_sv",    32'(bus.stage_valid), 32'd0);
    chk("midrst_cnt",   32'(bus.stall_count), 32'd0);
    drive(1,0,0,0,0,0,0,0,0,0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();

    // randomized traffic against the queue model
    for (int c = 0; c < 600; c++) begin
      int  en, v, rs, rt, urs, urt, rw, mtr, dst, br;
      int  sa, sb, e_fa, e_fb, e_sv;
      bit  la, lb, ha, hb, e_stall, e_flush;
      en  = ($urandom_range(0, 9) != 0) ? 1 : 0;
      v   = ($urandom_range(0, 4) != 0) ? 1 : 0;
      rs  = $urandom_range(0, 7);
      rt  = $urandom_range(0, 7);
      urs = $urandom_range(0, 1);
      urt = $urandom_range(0, 1);
      rw  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      mtr = ($urandom_range(0, 2) == 0) ? 1 : 0;
      dst = $urandom_range(0, 7);
      br  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      drive(en, v, rs, rt, urs, urt, rw, mtr, dst, br);
      sa = find_stage(rs, urs, la);
      sb = find_stage(rt, urt, lb);
      ha = (sa != 0) && la && (sa < LR);
      hb = (sb != 0) && lb && (sb < LR);
      e_stall = (v != 0) && (ha || hb);
      e_flush = (v != 0) && (br != 0) && !e_stall;
      e_fa = ((v != 0) && !e_stall) ? sa : 0;
      e_fb = ((v != 0) && !e_stall) ? sb : 0;
      e_sv = 0;
      foreach (q[i]) if (q[i].v) e_sv += (1 << i);
      @(negedge clk);
      chk("rnd_stall", 32'(bus.stall),       32'(e_stall));
      chk("rnd_flush", 32'(bus.flush_if_id), 32'(e_flush));
      chk("rnd_fwd_a", 32'(bus.fwd_a),       32'(e_fa));
      chk("rnd_fwd_b", 32'(bus.fwd_b),       32'(e_fb));
      chk("rnd_sv",    32'(bus.stage_valid), 32'(e_sv));
      chk("rnd_cnt",   32'(bus.stall_count), 32'(m_cnt));
      if (en != 0) begin
        q.push_front('{v: ((v != 0) && !e_stall), w: (rw != 0), l: (mtr != 0), d: dst});
        void'(q.pop_back());
        if (e_stall) m_cnt++;
      end
      @(posedge clk); #1;
    end

    // saturation on the 4-bit counter: back-to-back dependent loads stall 2 of every 3 cycles
    rst2 = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    chk("sat_cnt_9", 32'(bus2.stall_count), 32'd6);
    repeat (24) @(posedge clk);
    #1;
    chk("sat_cnt_33", 32'(bus2.stall_count), 32'd15);
    repeat (6) @(posedge clk);
    #1;
    chk("sat_cnt_hold", 32'(bus2.stall_count), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the in-order integer pipeline. It replaces the fixed 3-stage forwarding selector and the single-stage load-use detector. It keeps its own shadow scoreboard of the instructions in flight past decode (valid, reg_write, load, destination), one entry per stage. From that scoreboard it generates operand forwarding selects, the load-use stall, the IF/ID flush for taken decode-stage branches, and a saturating stall counter.

Parameters:
NUM_STAGES, 3, number of tracked stages after decode (1=EX, 2=MEM, 3=WB, ... NUM_STAGES); legal values 1..7.
REG_AW, 5, register address width.
LOAD_READY, 3, first stage index whose forwarded value is the load data; legal values 1..NUM_STAGES.
CNT_W, 16, stall counter width.
SELW, clog2(NUM_STAGES+1), forwarding select width (derived, not overridable).

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-low
enable  in  1  global advance; low = scoreboard and counter hold
id_valid  in  1  decode stage holds a real instruction
id_rs  in  REG_AW  source register A of decode instruction
id_rt  in  REG_AW  source register B of decode instruction
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt
id_reg_write  in  1  instruction writes a register
id_mem_to_reg  in  1  instruction is a load
id_dst  in  REG_AW  destination register after reg_dst selection
branch_taken  in  1  decode-stage branch resolved taken
stall  out  1  hold PC and IF/ID; inject bubble into stage 1
flush_if_id  out  1  clear IF/ID (squash fetched instruction)
fwd_a  out  SELW  operand A source: 0=register file, k=stage k result
fwd_b  out  SELW  operand B source, same encoding
stage_valid  out  NUM_STAGES  bit k-1 = stage k holds a valid instruction
stall_count  out  CNT_W  number of enabled stall cycles, saturating

Behaviour:
- Reset (rst=0, asynchronous): all scoreboard entries invalid; stall_count=0. While rst=0, stall, flush_if_id, fwd_a and fwd_b are forced to 0.
- Scoreboard entry k holds v, w, l, d (valid, reg_write, load, destination).
- Rising edge with enable=1:
  - Entry 1 loads {id_valid & ~stall, id_reg_write, id_mem_to_reg, id_dst}. A stall loads a bubble (v=0).
  - Entry k+1 loads entry k. Entry NUM_STAGES is discarded.
- enable=0: all entries and the counter hold. Combinational outputs still reflect the current state.
- Match for operand A:
  - Stage k matches when v[k] & w[k] & d[k]==id_rs & id_rs!=0 & id_uses_rs.
  - The youngest stage wins (smallest k).
  - No match gives fwd_a=0. Operand B is identical, using rt.
- Register 0 is never forwarded and never causes a stall.
- Load-use hazard: the winning stage k has l[k]=1 and k<LOAD_READY. A hazard is evaluated per operand.
- stall = id_valid & (hazard on A | hazard on B).
  - While stall=1, fwd_a=fwd_b=0.
  - When a hazard clears, fwd_a/fwd_b take the normal winning-stage value. For a load this is fwd=LOAD_READY.
- flush_if_id = branch_taken & id_valid & ~stall. Stall takes priority because the branch operands are not yet valid; the branch is re-evaluated on the next cycle.
- A flushed IF/ID does not affect the scoreboard. The branch itself still enters stage 1.
- Latency: outputs are combinational from the inputs and registered state, with zero-cycle latency. The scoreboard advances 1 stage per enabled cycle.
- With default parameters, a dependent instruction directly after a load stalls exactly 2 cycles.
- stall_count increments on each rising edge where enable=1 and stall=1. It holds at 2^CNT_W-1.
- id_valid=0: no stall, no flush, fwd=0. A bubble enters stage 1.

Test Plan:
1. ALU chain: write r3 (w=1, l=0), then 3 cycles of id_rs=3 → fwd_a=1, then 2, then 3, then 0 on the 4th cycle; stall stays 0.
2. Load-use: load to r5, next instruction id_rt=5 → stall=1 for 2 cycles, stage_valid=3'b010 then 3'b100, then fwd_b=3 with stall=0; stall_count=2.
3. Register 0 and priority: writer to r0 in stage 1 with id_rs=0 → fwd_a=0, no stall. Writers to r7 in stages 1 and 2 with id_rs=7 → fwd_a=1.
4. Branch: branch_taken=1 with no hazard → flush_if_id=1. branch_taken=1 during a load-use stall → flush_if_id=0, then 1 once the stall clears.
5. Enable/reset: enable=0 for 3 cycles during a stall → stage_valid and stall_count unchanged. Asserting rst=0 mid-stall → all outputs 0 immediately.
6. Saturation with CNT_W=4: hold a stall condition for 20 enabled cycles → stall_count=15.
